// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver (LSB first, idle-high line). Feeds the Caesar cipher core
//   with whole bytes over a valid/ready handshake. Framing errors and overruns
//   are reported as single-cycle pulses.
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BAUD          line rate in bit/s
//   CLKS_PER_BIT  clocks per bit cell (CLK_HZ/BAUD, must be >= 4)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   uart_rx    in   raw serial line, asynchronous to clk
//   rx_data    out  received byte, stable while rx_valid=1 (except on overrun)
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accepts on a cycle with rx_valid & rx_ready
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: new byte completed while rx_valid held
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Two-flop synchronizer, preset to the idle (high) line level so a reset
  // never looks like a start bit.
  logic meta_reg;
  logic rx_s_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      rx_s_reg <= 1'b1;
    end else begin
      meta_reg <= uart_rx;
      rx_s_reg <= meta_reg;
    end
  end

  state_t           state_reg,     state_next;
  logic [CNT_W-1:0] cnt_reg,       cnt_next;
  logic [2:0]       bit_idx_reg,   bit_idx_next;
  logic [7:0]       shift_reg,     shift_next;
  logic [7:0]       data_reg,      data_next;
  logic             valid_reg,     valid_next;
  logic             frame_err_reg, frame_err_next;
  logic             overrun_reg,   overrun_next;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    // rx_ready only matters while a byte is being offered.
    accept = valid_reg & rx_ready;
    if (accept) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg) begin
          state_next = ST_START;
        end
      end

      // Re-check the line half a bit in; a high level here was a glitch.
      ST_START: begin
        if (cnt_reg == CNT_MID) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            state_next = ST_IDLE;
          end else begin
            bit_idx_next = 3'd0;
            state_next   = ST_DATA;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Counter was restarted mid start bit, so every wrap lands mid data bit.
      ST_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s_reg;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            // A byte accepted in this same cycle frees the slot: no overrun.
            data_next    = shift_reg;
            valid_next   = 1'b1;
            overrun_next = valid_reg & ~accept;
            state_next   = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Wait out a held-low line so it yields only one frame_err.
      ST_BREAK: begin
        cnt_next = '0;
        if (rx_s_reg) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_data   = data_reg;
  assign rx_valid  = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
